// File: rtl/instruction_fetch.sv
// Instruction fetch stage for the MIPS core: PC register, next-PC selection,
// instruction-memory request/ready handshake, a one-entry skid buffer and the
// IF/ID pipeline register. Branch/jump redirects arrive from decode (based on
// the instruction currently held in IF/ID) and resolve here; no delay slot.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   imem_req       fetch request (registered)
//   imem_addr      fetch address = current PC (registered, word aligned)
//   imem_rdata     instruction word, valid when imem_ready=1
//   imem_ready     memory completes the outstanding request this cycle
//   stall          decode cannot accept a new instruction
//   branch_taken   BEQ/BNE in IF/ID resolved taken (wins over jump)
//   jump           IF/ID holds J/JAL
//   ifid_valid     IF/ID holds a live instruction
//   ifid_instr     instruction in IF/ID (0 when flushed)
//   ifid_pc_plus4  PC+4 of the IF/ID instruction
module instruction_fetch #(
  parameter logic [31:0] PC_RESET = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic        jump,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_req, w_req_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_ifid_valid, w_ifid_valid_nxt;
  logic [31:0] r_ifid_instr, w_ifid_instr_nxt;
  logic [31:0] r_ifid_pc4, w_ifid_pc4_nxt;
  logic [31:0] r_skid_instr, w_skid_instr_nxt;
  logic [31:0] r_skid_pc4, w_skid_pc4_nxt;
  logic        r_pend, w_pend_nxt;
  logic [31:0] r_pend_tgt, w_pend_tgt_nxt;

  logic        w_fire;
  logic        w_redirect;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;

  function automatic logic [31:0] branch_target(input logic [31:0] pc4,
                                                input logic [15:0] imm);
    return pc4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

  function automatic logic [31:0] jump_target(input logic [3:0]  pc4_hi,
                                              input logic [25:0] idx);
    return {pc4_hi, idx, 2'b00};
  endfunction

  // Only a fetch that is actually outstanding can complete; the first cycle
  // after reset has no request on the bus yet.
  assign w_fire     = r_req & imem_ready;
  assign w_redirect = r_ifid_valid & (branch_taken | jump);
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_target   = branch_taken ? branch_target(r_ifid_pc4, r_ifid_instr[15:0])
                                   : jump_target(r_ifid_pc4[31:28], r_ifid_instr[25:0]);

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_ifid_valid_nxt = r_ifid_valid;
    w_ifid_instr_nxt = r_ifid_instr;
    w_ifid_pc4_nxt   = r_ifid_pc4;
    w_skid_instr_nxt = r_skid_instr;
    w_skid_pc4_nxt   = r_skid_pc4;
    w_pend_nxt       = r_pend;
    w_pend_tgt_nxt   = r_pend_tgt;

    if (r_state == S_FETCH) begin
      if (r_pend) begin
        // The request in flight when the redirect arrived must finish before
        // the address may change; its data belongs to the dead path.
        if (w_fire) begin
          w_pc_nxt   = r_pend_tgt;
          w_pend_nxt = 1'b0;
        end
      end else if (w_redirect) begin
        w_ifid_valid_nxt = 1'b0;
        w_ifid_instr_nxt = '0;
        if (w_fire || !r_req) begin
          w_pc_nxt = w_target;
        end else begin
          w_pend_nxt     = 1'b1;
          w_pend_tgt_nxt = w_target;
        end
      end else if (w_fire) begin
        w_pc_nxt = w_pc_plus4;
        if (!stall) begin
          w_ifid_valid_nxt = 1'b1;
          w_ifid_instr_nxt = imem_rdata;
          w_ifid_pc4_nxt   = w_pc_plus4;
        end else begin
          // Decode is blocked: park the word so the bus request can drop.
          w_skid_instr_nxt = imem_rdata;
          w_skid_pc4_nxt   = w_pc_plus4;
          w_state_nxt      = S_HOLD;
        end
      end
    end else begin
      if (w_redirect) begin
        w_pc_nxt         = w_target;
        w_ifid_valid_nxt = 1'b0;
        w_ifid_instr_nxt = '0;
        w_state_nxt      = S_FETCH;
      end else if (!stall) begin
        w_ifid_valid_nxt = 1'b1;
        w_ifid_instr_nxt = r_skid_instr;
        w_ifid_pc4_nxt   = r_skid_pc4;
        w_state_nxt      = S_FETCH;
      end
    end

    // Request is a register so it never depends combinationally on inputs.
    w_req_nxt = (w_state_nxt == S_FETCH);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_FETCH;
      r_req        <= 1'b0;
      r_pc         <= PC_RESET;
      r_ifid_valid <= 1'b0;
      r_ifid_instr <= '0;
      r_ifid_pc4   <= '0;
      r_skid_instr <= '0;
      r_skid_pc4   <= '0;
      r_pend       <= 1'b0;
      r_pend_tgt   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_req        <= w_req_nxt;
      r_pc         <= w_pc_nxt;
      r_ifid_valid <= w_ifid_valid_nxt;
      r_ifid_instr <= w_ifid_instr_nxt;
      r_ifid_pc4   <= w_ifid_pc4_nxt;
      r_skid_instr <= w_skid_instr_nxt;
      r_skid_pc4   <= w_skid_pc4_nxt;
      r_pend       <= w_pend_nxt;
      r_pend_tgt   <= w_pend_tgt_nxt;
    end
  end

  assign imem_req      = r_req;
  assign imem_addr     = r_pc;
  assign ifid_valid    = r_ifid_valid;
  assign ifid_instr    = r_ifid_instr;
  assign ifid_pc_plus4 = r_ifid_pc4;

endmodule
